ppm_encoder: RTL and testbench
==============================

Name: ppm_encoder

Overview:
- Downstream consumer of the LED_setter AXI4-Lite slave registers.
- Takes per-channel pulse widths (in µs) from the slave registers and generates a standard PPM frame on a single output pin for the UAV receiver interface.
- Double-buffers the channel values at each frame start, so AXI writes never glitch a frame in progress.

Parameters:
- NUM_CH, 4: number of PPM channels, one slave register each.
- TICKS_PER_US, 100: ACLK cycles per µs (100 MHz).
- SEP_US, 300: low separator pulse length, µs.
- MIN_US, 800: lower clamp for channel width, µs.
- MAX_US, 2200: upper clamp for channel width, µs.
- MIN_SYNC_US, 2500: minimum sync (high) gap at end of frame, µs.
- DEFAULT_FRAME_US, 20000: frame length used when frame_us == 0.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous reset, active low.
- en  in  1  frame generation enable.
- ch_width_flat  in  NUM_CH*32  slave registers; channel k is at [32k+15:32k]. Bits [32k+31:32k+16] are ignored.
- frame_us  in  16  frame period in µs; 0 selects DEFAULT_FRAME_US.
- ppm_out  out  1  PPM signal; idle level is high.
- frame_start  out  1  one-cycle pulse when a frame begins.
- busy  out  1  high while a frame is in progress.
- ch_idx  out  $clog2(NUM_CH)  channel currently being emitted.

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is synchronous and active low, sampled on the rising edge of ACLK.
- Reset values: ppm_out=1, frame_start=0, busy=0, ch_idx=0, state=IDLE, all counters 0, shadow widths=MIN_US.
- µs tick: prescaler counts 0..TICKS_PER_US-1 and asserts tick when the count equals TICKS_PER_US-1. The prescaler is held at 0 in IDLE. All µs counters advance only on tick.
- IDLE: if en=1 then in the same cycle:
  - latch the clamped widths into the shadow registers;
  - latch the effective frame length;
  - pulse frame_start;
  - go to SEP with ch_idx=0.
  - Output latency: ppm_out falls on the following cycle.
- SEP: ppm_out=0 for SEP_US ticks.
  - If ch_idx < NUM_CH, go to CH.
  - Otherwise (trailing separator), go to SYNC.
- CH: ppm_out=1 for (shadow[ch_idx] - SEP_US) ticks, then ch_idx++ and go to SEP. The sequence is SEP,CH repeated NUM_CH times, then one trailing SEP.
- SYNC: ppm_out=1. Exit when both conditions hold: elapsed_us >= frame length, and sync_us >= MIN_SYNC_US.
  - On exit with en=1: relatch as in IDLE, pulse frame_start, go to SEP. There is no idle cycle between frames.
  - On exit with en=0: go to IDLE.
- elapsed_us: counts from frame start. It is 17 bits and saturates; it never wraps.
- Clamp: width < MIN_US becomes MIN_US; width > MAX_US becomes MAX_US. Clamping is applied at latch time.
- Overrun: if the sum of widths + SEP_US exceeds the frame length, the frame stretches. The sync gap is exactly MIN_SYNC_US.
- Deasserting en mid-frame: the current frame completes, then the block goes to IDLE.
- Register writes mid-frame: no effect until the next frame_start.
- busy: 1 in every state except IDLE.
- Reset mid-frame: the next cycle shows the reset values; no partial pulse is emitted.

Optional Feature:
- Macro: PPM_FRAME_CNT_EN.
- Defined: adds output frame_cnt (32-bit). It resets to 0, increments on each frame_start, and wraps 0xFFFFFFFF -> 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package ppm_pkg:
  - state enum ppm_state_t {IDLE, SEP, CH, SYNC};
  - localparam widths (US_W=17, CH_W=16);
  - clamp function.
- Sub-module us_prescaler:
  - ports: ACLK, ARESETN, clr, tick;
  - parameter TICKS_PER_US.

Test Plan:
- Nominal frame (TICKS_PER_US=2, widths 1000/1500/2000/1200, frame_us=20000, en=1):
  - 5 low pulses of 600 cycles each;
  - high times of 1400/2400/3400/1800 cycles;
  - sync 28000 cycles;
  - frame_start period 40000 cycles.
- Clamp (ch0=500, ch1=3000, ch1 upper bits 0xDEAD): ch0 high time = 500 µs, ch1 high time = 1900 µs; the upper bits are ignored.
- Overrun (4×2000, frame_us=4000): sync = 2500 µs; total frame = 8000+300+2500 = 10800 µs.
- Mid-frame write (ch0 changes 1000->1800 during CH of ch2): current frame unchanged; next frame ch0 high time = 1500 µs.
- en dropped during ch1: the frame completes normally; busy falls after SYNC; no further frame_start.
- Reset during CH: the next cycle shows ppm_out=1, busy=0. After release with en=1, a fresh frame starts with ch_idx=0 (and frame_cnt=1 when PPM_FRAME_CNT_EN is defined).

Source files
------------

// File: rtl/ppm_pkg.sv
`default_nettype none
// ============================================================================
// ppm_pkg : shared state type, counter widths and channel-width clamp
// Revision: 1.0
// ============================================================================
package ppm_pkg;

    localparam int US_W = 17;
    localparam int CH_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEP  = 2'd1,
        CH   = 2'd2,
        SYNC = 2'd3
    } ppm_state_t;

    function automatic logic [CH_W-1:0] clamp_us(
        input logic [CH_W-1:0] w,
        input logic [CH_W-1:0] lo,
        input logic [CH_W-1:0] hi
    );
        if (w < lo)
            return lo;
        else if (w > hi)
            return hi;
        else
            return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppm_encoder_prescaler.sv
`default_nettype none
// ============================================================================
// us_prescaler : divides ACLK down to a one-cycle tick per microsecond
// Revision: 1.0
// ============================================================================
module us_prescaler #(
    parameter int TICKS_PER_US = 100
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_US - 1);

    logic [CW-1:0] r_cnt;

    assign tick = !clr && (r_cnt == C_LAST);

    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_cnt <= '0;
        else if (clr || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/ppm_encoder.sv
`default_nettype none
// ============================================================================
// ppm_encoder : double-buffered multi-channel PPM frame generator
// Optional frame counter output enabled by `define PPM_FRAME_CNT_EN
// Revision: 1.0
// ============================================================================
module ppm_encoder
    import ppm_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int TICKS_PER_US     = 100,
    parameter int SEP_US           = 300,
    parameter int MIN_US           = 800,
    parameter int MAX_US           = 2200,
    parameter int MIN_SYNC_US      = 2500,
    parameter int DEFAULT_FRAME_US = 20000
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      en,
    input  logic [NUM_CH*32-1:0]      ch_width_flat,
    input  logic [15:0]               frame_us,
    output logic                      ppm_out,
    output logic                      frame_start,
    output logic                      busy,
`ifdef PPM_FRAME_CNT_EN
    output logic [31:0]               frame_cnt,
`endif
    output logic [$clog2(NUM_CH)-1:0] ch_idx
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] C_NUM_CH   = CNT_W'(NUM_CH);
    localparam logic [CH_W-1:0]  C_SEP_LAST = CH_W'(SEP_US - 1);
    localparam logic [US_W-1:0]  C_MIN_SYNC = US_W'(MIN_SYNC_US);

    ppm_state_t       r_state;
    logic [CNT_W-1:0] r_ch;
    logic [CH_W-1:0]  r_seg;
    logic [US_W-1:0]  r_el;
    logic [US_W-1:0]  r_sync;
    logic [US_W-1:0]  r_flen;
    logic [CH_W-1:0]  r_shadow [NUM_CH];
    logic             r_ppm;
    logic             r_fs;

    logic             w_tick;
    logic             w_start;
    logic             w_sync_done;
    logic             w_unused_hi;
    logic [US_W-1:0]  w_el_next;
    logic [US_W-1:0]  w_flen;
    logic [CH_W-1:0]  w_ch_last;
    logic [CH_W-1:0]  w_clamped [NUM_CH];

    us_prescaler #(
        .TICKS_PER_US (TICKS_PER_US)
    ) u_prescaler (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr     (r_state == IDLE),
        .tick    (w_tick)
    );

    // Upper halves of the slave registers carry no channel data.
    always_comb begin
        w_unused_hi = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_clamped[k] = clamp_us(ch_width_flat[32*k +: CH_W], CH_W'(MIN_US), CH_W'(MAX_US));
            w_unused_hi  = w_unused_hi ^ (^ch_width_flat[32*k+CH_W +: 32-CH_W]);
        end
    end

    assign w_flen      = (frame_us == 16'd0) ? US_W'(DEFAULT_FRAME_US) : US_W'(frame_us);
    assign w_ch_last   = r_shadow[r_ch[IDX_W-1:0]] - CH_W'(SEP_US + 1);
    assign w_el_next   = (r_el == {US_W{1'b1}}) ? r_el : r_el + 1'b1;
    assign w_sync_done = (w_el_next >= r_flen) && ((r_sync + 1'b1) >= C_MIN_SYNC);
    assign w_start     = en && ((r_state == IDLE) ||
                                ((r_state == SYNC) && w_tick && w_sync_done));

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_ppm   <= 1'b1;
            r_fs    <= 1'b0;
            r_ch    <= '0;
            r_seg   <= '0;
            r_el    <= '0;
            r_sync  <= '0;
            r_flen  <= '0;
            for (int k = 0; k < NUM_CH; k++)
                r_shadow[k] <= CH_W'(MIN_US);
        end else begin
            r_fs <= 1'b0;
            if (w_tick)
                r_el <= w_el_next;
            // A frame start (from IDLE or back-to-back out of SYNC) overrides all counting.
            if (w_start) begin
                for (int k = 0; k < NUM_CH; k++)
                    r_shadow[k] <= w_clamped[k];
                r_flen  <= w_flen;
                r_fs    <= 1'b1;
                r_ch    <= '0;
                r_seg   <= '0;
                r_el    <= '0;
                r_sync  <= '0;
                r_ppm   <= 1'b0;
                r_state <= SEP;
            end else if (w_tick) begin
                unique case (r_state)
                    SEP: begin
                        if (r_seg == C_SEP_LAST) begin
                            r_seg   <= '0;
                            r_ppm   <= 1'b1;
                            r_state <= (r_ch == C_NUM_CH) ? SYNC : CH;
                        end else begin
                            r_seg <= r_seg + 1'b1;
                        end
                    end
                    CH: begin
                        if (r_seg == w_ch_last) begin
                            r_seg   <= '0;
                            r_ch    <= r_ch + 1'b1;
                            r_ppm   <= 1'b0;
                            r_state <= SEP;
                        end else begin
                            r_seg <= r_seg + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (w_sync_done) begin
                            r_state <= IDLE;
                            r_ch    <= '0;
                            r_el    <= '0;
                            r_sync  <= '0;
                        end else begin
                            r_sync <= r_sync + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PPM_FRAME_CNT_EN
    logic [31:0] r_frame_cnt;

    always_ff @(posedge ACLK) begin
        if (!ARESETN)
            r_frame_cnt <= '0;
        else if (w_start)
            r_frame_cnt <= r_frame_cnt + 1'b1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign ppm_out     = r_ppm;
    assign frame_start = r_fs;
    assign busy        = (r_state != IDLE);
    assign ch_idx      = r_ch[IDX_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ppm_encoder.sv
`default_nettype none
// ============================================================================
// tb_ppm_encoder : randomized self-checking bench with a frame-level PPM model
// Revision: 1.0
// ============================================================================
module tb_ppm_encoder;

    localparam int T    = 2;
    localparam int NCH  = 4;
    localparam int SEP  = 300;
    localparam int MINW = 800;
    localparam int MAXW = 2200;
    localparam int MINS = 2500;
    localparam int DEFF = 20000;

    logic             ACLK = 1'b0;
    logic             ARESETN;
    logic             en;
    logic [NCH*32-1:0] ch_width_flat;
    logic [15:0]      frame_us;
    logic             ppm_out;
    logic             frame_start;
    logic             busy;
    logic [1:0]       ch_idx;
`ifdef PPM_FRAME_CNT_EN
    logic [31:0]      frame_cnt;
`endif

    int          n_total = 0;
    int          n_bad   = 0;
    int          fs_seen;
    int          exp_fcnt;
    logic [31:0] img_w [NCH];
    int          img_fus;

    always #5 ACLK = ~ACLK;

    ppm_encoder #(
        .NUM_CH       (NCH),
        .TICKS_PER_US (T)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .en            (en),
        .ch_width_flat (ch_width_flat),
        .frame_us      (frame_us),
        .ppm_out       (ppm_out),
        .frame_start   (frame_start),
        .busy          (busy),
`ifdef PPM_FRAME_CNT_EN
        .frame_cnt     (frame_cnt),
`endif
        .ch_idx        (ch_idx)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampw(input logic [31:0] r);
        int w;
        w = int'(r[15:0]);
        if (w < MINW) return MINW;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    task automatic drive_regs();
        for (int k = 0; k < NCH; k++)
            ch_width_flat[32*k +: 32] = img_w[k];
        frame_us = img_fus[15:0];
    endtask

    task automatic apply_action(input int code);
        if (code == 1) begin
            img_w[0] = 32'd500;
            img_w[1] = 32'hDEAD_0BB8;
            img_w[2] = 32'd2000;
            img_w[3] = 32'd2000;
            img_fus  = 4000;
            drive_regs();
        end else if (code == 2) begin
            img_w[0] = 32'd1800;
            for (int k = 1; k < NCH; k++)
                img_w[k] = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 1600));
            img_fus = int'($urandom_range(1, 9000));
            drive_regs();
        end else if (code == 3) begin
            en = 1'b0;
        end
    endtask

    // Length of the current run of ppm_out at level lvl while busy, in cycles.
    task automatic run_len(input logic lvl, input int lim, input int act_off,
                           input int act_code, output int n);
        n = 0;
        while (ppm_out == lvl && busy && n < lim) begin
            if (frame_start) fs_seen++;
            n++;
            if (n == act_off) apply_action(act_code);
            @(negedge ACLK);
        end
    endtask

    // Called on the first sample of a frame; expectations come from the register image.
    task automatic check_frame(input string tag, input int act_seg, input int act_off,
                               input int act_code, input bit exp_next);
        int exp_len [2*NCH+2];
        int pre, flen, n, meas;
        flen = (img_fus == 0) ? DEFF : img_fus;
        pre  = SEP;
        for (int k = 0; k < NCH; k++) begin
            exp_len[2*k]   = SEP;
            exp_len[2*k+1] = clampw(img_w[k]) - SEP;
            pre += clampw(img_w[k]);
        end
        exp_len[2*NCH]   = SEP;
        exp_len[2*NCH+1] = (flen - pre > MINS) ? flen - pre : MINS;
        exp_fcnt++;
        check_val({tag, " frame_start"}, frame_start, 1);
`ifdef PPM_FRAME_CNT_EN
        check_val({tag, " frame_cnt"}, frame_cnt, exp_fcnt);
`endif
        fs_seen = 0;
        meas    = 0;
        for (int s = 0; s < 2*NCH+2; s++) begin
            if (s < 2*NCH)
                check_val($sformatf("%s ch_idx seg%0d", tag, s), ch_idx, s / 2);
            run_len(1'(s % 2), exp_len[s]*T + 64, (s == act_seg) ? act_off : 0, act_code, n);
            check_val($sformatf("%s seg%0d len", tag, s), n, exp_len[s]*T);
            meas += n;
        end
        check_val({tag, " period"}, meas, (pre + exp_len[2*NCH+1]) * T);
        check_val({tag, " single frame_start"}, fs_seen, 1);
        check_val({tag, " next frame_start"}, frame_start, exp_next);
        check_val({tag, " busy after"}, busy, exp_next);
    endtask

    task automatic wait_start(input string tag, input int lim);
        int n;
        n = 0;
        while (!frame_start && n < lim) begin
            @(negedge ACLK);
            n++;
        end
        check_val({tag, " start latency"}, n, 1);
    endtask

    initial begin
        int n;
        int idle_fs, idle_busy;
        ARESETN  = 1'b0;
        en       = 1'b0;
        exp_fcnt = 0;
        img_w[0] = 32'd1000;
        img_w[1] = 32'd1500;
        img_w[2] = 32'd2000;
        img_w[3] = 32'd1200;
        img_fus  = 20000;
        drive_regs();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_val("reset ppm_out", ppm_out, 1);
        check_val("reset frame_start", frame_start, 0);
        check_val("reset busy", busy, 0);
        check_val("reset ch_idx", ch_idx, 0);
`ifdef PPM_FRAME_CNT_EN
        check_val("reset frame_cnt", frame_cnt, 0);
`endif
        ARESETN = 1'b1;
        repeat (10) @(negedge ACLK);
        check_val("idle busy", busy, 0);
        check_val("idle ppm_out", ppm_out, 1);

        // Nominal frame; overrun/clamp registers written during its sync gap.
        en = 1'b1;
        wait_start("nom", 10);
        check_frame("nom", 2*NCH+1, 20, 1, 1'b1);
        // Overrun + clamp frame; new values written during CH of ch2.
        check_frame("ovr", 5, 100, 2, 1'b1);
        // Random frame, en dropped during ch1.
        check_frame("rnd", 3, 50, 3, 1'b0);

        idle_fs   = 0;
        idle_busy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ACLK);
            if (frame_start) idle_fs++;
            if (busy) idle_busy++;
        end
        check_val("after drop frame_start", idle_fs, 0);
        check_val("after drop busy", idle_busy, 0);
        check_val("after drop ppm_out", ppm_out, 1);
        check_val("after drop ch_idx", ch_idx, 0);

        // Reset in the middle of a channel pulse.
        for (int k = 0; k < NCH; k++)
            img_w[k] = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 1600));
        img_fus = int'($urandom_range(1, 9000));
        drive_regs();
        en = 1'b1;
        wait_start("rst", 10);
        run_len(1'b0, SEP*T + 64, 0, 0, n);
        check_val("rst first sep", n, SEP*T);
        repeat (int'($urandom_range(5, 300))) @(negedge ACLK);
        check_val("rst in ch", ppm_out, 1);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check_val("rst ppm_out", ppm_out, 1);
        check_val("rst busy", busy, 0);
        check_val("rst ch_idx", ch_idx, 0);
        check_val("rst frame_start", frame_start, 0);
`ifdef PPM_FRAME_CNT_EN
        check_val("rst frame_cnt", frame_cnt, 0);
`endif
        ARESETN = 1'b1;
        @(negedge ACLK);
        check_val("restart frame_start", frame_start, 1);
        check_val("restart busy", busy, 1);
        check_val("restart ppm_out", ppm_out, 0);
        check_val("restart ch_idx", ch_idx, 0);
`ifdef PPM_FRAME_CNT_EN
        check_val("restart frame_cnt", frame_cnt, 1);
`endif
        run_len(1'b0, SEP*T + 64, 0, 0, n);
        check_val("restart sep", n, SEP*T);
        check_val("restart ch_idx in ch0", ch_idx, 0);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
